// File: rtl/prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch stage: default queue
// depth, FSM state type and the segment:offset physical-address helper.
package prefetch_unit_pkg;

   localparam int PREFETCH_DEPTH = 6;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WRITE_HI
   } prefetch_state_e;

   // Real-mode physical address: segment * 16 + offset, wrapped to 20 bits.
   function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
      return {seg, 4'h0} + {4'h0, off};
   endfunction

endpackage

// File: rtl/prefetch_unit_if.sv
// Bus bundle of the prefetch stage: code segment / restart control, the
// word-wide memory read port and the byte-wide queue read port.
// The master side is the prefetch unit itself (it issues memory requests and
// sources queue bytes); the slave side is memory plus the queue consumers.
interface prefetch_unit_if;

   logic [15:0] cs;
   logic [15:0] new_ip;
   logic        load_new_ip;
   logic        mem_access;
   logic        mem_ack;
   logic [18:0] mem_address;
   logic [15:0] mem_data;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data;
   logic        fifo_empty;

   modport master (
      input  cs, new_ip, load_new_ip, mem_ack, mem_data, fifo_rd_en,
      output mem_access, mem_address, fifo_rd_data, fifo_empty
   );

   modport slave (
      output cs, new_ip, load_new_ip, mem_ack, mem_data, fifo_rd_en,
      input  mem_access, mem_address, fifo_rd_data, fifo_empty
   );

endinterface

// File: rtl/prefetch_fifo.sv
// Byte queue for the prefetch stage. Circular buffer with occupancy count,
// registered read data and a synchronous flush that wins over read and write.
module prefetch_fifo
   import prefetch_unit_pkg::*;
#(
   parameter int DEPTH = PREFETCH_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [7:0]       wr_data_i,
   input  logic             rd_en_i,
   output logic [7:0]       rd_data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [7:0]       rd_data_q;
   logic             do_wr, do_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A pop on an empty queue is ignored; a flush cancels both pop and push.
   assign do_rd = rd_en_i && (count_q != '0) && !flush_i;
   assign do_wr = wr_en_i && (count_q != CNT_W'(DEPTH)) && !flush_i;

   // Byte storage write port.
   // NOTE: the storage array has no reset; occupancy and pointers alone define
   // which entries are valid, so clearing the array would only add fan-out.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Pointers, occupancy count and registered read data.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_rd) begin
            rd_ptr_q  <= ptr_inc(rd_ptr_q);
            rd_data_q <= mem_q[rd_ptr_q];
         end
         if (do_wr && !do_rd)      count_q <= count_q + CNT_W'(1);
         else if (do_rd && !do_wr) count_q <= count_q - CNT_W'(1);
      end
   end

   assign rd_data_o = rd_data_q;
   assign count_o   = count_q;
   assign empty_o   = (count_q == '0);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch stage: fetches 16-bit words at CS:IP and feeds them
// byte-by-byte into the prefetch queue; load_new_ip flushes and restarts.
module prefetch_unit
   import prefetch_unit_pkg::*;
#(
   parameter int FIFO_DEPTH = PREFETCH_DEPTH
) (
   input  logic           clk,
   input  logic           reset,
   prefetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   prefetch_state_e  state_q, state_d;
   logic [15:0]      fetch_ip_q, fetch_ip_d;
   logic [18:0]      mem_address_q, mem_address_d;
   logic [7:0]       hi_byte_q, hi_byte_d;
   logic             discard_q, discard_d;

   logic             push_en;
   logic [7:0]       push_data;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] free_slots;
   logic             start_fetch;
   logic [19:0]      req_phys;

   // An odd fetch_ip consumes only the high byte of the word, so one free slot
   // is enough; an even one needs room for both bytes.
   assign free_slots  = CNT_W'(FIFO_DEPTH) - fifo_count;
   assign start_fetch = (free_slots >= CNT_W'(2)) ||
                        ((free_slots != '0) && fetch_ip_q[0]);
   assign req_phys    = phys_addr(bus.cs, fetch_ip_q);

   // Next-state, fetch pointer and queue-push decode.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      fetch_ip_d    = fetch_ip_q;
      mem_address_d = mem_address_q;
      hi_byte_d     = hi_byte_q;
      discard_d     = discard_q;
      push_en       = 1'b0;
      push_data     = hi_byte_q;
      unique case (state_q)
         IDLE: begin
            if (bus.load_new_ip) begin
               fetch_ip_d = bus.new_ip;
            end else if (start_fetch) begin
               state_d       = FETCH;
               mem_address_d = req_phys[19:1];
            end
         end
         FETCH: begin
            if (bus.mem_ack) begin
               state_d   = IDLE;
               discard_d = 1'b0;
               if (bus.load_new_ip) begin
                  fetch_ip_d = bus.new_ip;
               end else if (!discard_q) begin
                  push_en    = 1'b1;
                  fetch_ip_d = fetch_ip_q + 16'd1;
                  if (fetch_ip_q[0]) begin
                     push_data = bus.mem_data[15:8];
                  end else begin
                     push_data = bus.mem_data[7:0];
                     hi_byte_d = bus.mem_data[15:8];
                     state_d   = WRITE_HI;
                  end
               end
            end else if (bus.load_new_ip) begin
               // Request stays on the bus until acked; its data is dropped.
               discard_d  = 1'b1;
               fetch_ip_d = bus.new_ip;
            end
         end
         WRITE_HI: begin
            state_d = IDLE;
            if (bus.load_new_ip) begin
               fetch_ip_d = bus.new_ip;
            end else begin
               push_en    = 1'b1;
               fetch_ip_d = fetch_ip_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         fetch_ip_q    <= '0;
         mem_address_q <= '0;
         hi_byte_q     <= '0;
         discard_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_ip_q    <= fetch_ip_d;
         mem_address_q <= mem_address_d;
         hi_byte_q     <= hi_byte_d;
         discard_q     <= discard_d;
      end
   end

   assign bus.mem_access  = (state_q == FETCH);
   assign bus.mem_address = mem_address_q;

   prefetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (bus.load_new_ip),
      .wr_en_i   (push_en),
      .wr_data_i (push_data),
      .rd_en_i   (bus.fifo_rd_en),
      .rd_data_o (bus.fifo_rd_data),
      .count_o   (fifo_count),
      .empty_o   (bus.fifo_empty)
   );

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios followed by a
// randomized pop/flush phase checked against a byte-stream reference model.
module tb_prefetch_unit;

   logic clk = 1'b0;
   logic reset;

   prefetch_unit_if bus ();

   prefetch_unit #(.FIFO_DEPTH(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [15:0] ovr_mem [int];

   function automatic logic [7:0] hash_byte(input logic [19:0] p);
      return p[7:0] ^ {p[11:8], p[15:12]} ^ {p[19:16], 4'h0} ^ 8'h5A;
   endfunction

   function automatic logic [15:0] mem_word(input logic [18:0] wa);
      if (ovr_mem.exists(int'(wa))) return ovr_mem[int'(wa)];
      return {hash_byte({wa, 1'b1}), hash_byte({wa, 1'b0})};
   endfunction

   function automatic logic [7:0] mem_byte(input logic [19:0] p);
      logic [15:0] w;
      w = mem_word(p[19:1]);
      return p[0] ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [19:0] tb_phys(input logic [15:0] seg, input logic [15:0] off);
      return 20'((int'(seg) * 16 + int'(off)) % 1048576);
   endfunction

   // ---------------- memory responder ----------------
   int          mem_lat = 0;
   logic [18:0] req_q [$];
   bit          req_active = 1'b0;
   logic [18:0] req_addr = '0;
   int          wait_cnt = 0;

   initial begin
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            req_active  = 1'b0;
         end else if (bus.mem_access) begin
            if (!req_active) begin
               req_active = 1'b1;
               req_addr   = bus.mem_address;
               req_q.push_back(bus.mem_address);
               wait_cnt   = 0;
            end else begin
               check("addr_stable", 32'(bus.mem_address), 32'(req_addr));
            end
            if (wait_cnt >= mem_lat) begin
               bus.mem_ack  = 1'b1;
               bus.mem_data = mem_word(req_addr);
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // ---------------- reference byte stream ----------------
   logic [15:0] exp_ip = '0;
   logic [15:0] exp_cs = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush(input logic [15:0] ip, input logic [15:0] seg, input bit with_pop);
      bus.cs          = seg;
      bus.new_ip      = ip;
      bus.load_new_ip = 1'b1;
      bus.fifo_rd_en  = with_pop;
      tick();
      bus.load_new_ip = 1'b0;
      bus.fifo_rd_en  = 1'b0;
      req_q.delete();
      exp_ip = ip;
      exp_cs = seg;
   endtask

   task automatic wait_nonempty(input string tag, input int budget);
      int n = 0;
      while (bus.fifo_empty && n < budget) begin
         tick();
         n++;
      end
      if (bus.fifo_empty) check(tag, 32'(bus.fifo_empty), 32'd0);
   endtask

   // Pops one byte and compares it with the model; returns the popped byte.
   task automatic pop_check(input string tag, output logic [7:0] b);
      wait_nonempty({tag, "_wait"}, 100);
      bus.fifo_rd_en = 1'b1;
      tick();
      bus.fifo_rd_en = 1'b0;
      b = bus.fifo_rd_data;
      check(tag, 32'(b), 32'(mem_byte(tb_phys(exp_cs, exp_ip))));
      exp_ip = exp_ip + 16'd1;
   endtask

   task automatic wait_reqs(input string tag, input int n, input int budget);
      int c = 0;
      while (req_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      if (req_q.size() < n) check(tag, 32'(req_q.size()), 32'(n));
   endtask

   function automatic logic [18:0] req_at(input int i);
      if (i < req_q.size()) return req_q[i];
      return '0;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      logic [7:0] prev;
      bit         was_empty;
      int         n;

      reset           = 1'b0;
      bus.cs          = 16'h1000;
      bus.new_ip      = 16'h0100;
      bus.load_new_ip = 1'b1;
      bus.fifo_rd_en  = 1'b0;
      ovr_mem[int'(19'h08080)] = 16'hBBAA;
      ovr_mem[int'(19'h00001)] = 16'h1122;

      // Reset state, with load_new_ip held (ignored while in reset).
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_access",  32'(bus.mem_access),   32'd0);
      check("rst_mem_address", 32'(bus.mem_address),  32'd0);
      check("rst_rd_data",     32'(bus.fifo_rd_data), 32'd0);
      check("rst_empty",       32'(bus.fifo_empty),   32'd1);

      // Test 1: flush to 0x0100 right out of reset, cs = 0x1000.
      reset = 1'b1;
      tick();
      bus.load_new_ip = 1'b0;
      req_q.delete();
      exp_ip = 16'h0100;
      exp_cs = 16'h1000;
      check("t1_empty", 32'(bus.fifo_empty), 32'd1);
      wait_reqs("t1_req_timeout", 1, 20);
      check("t1_req0", 32'(req_at(0)), 32'h08080);
      pop_check("t1_pop_lo", b);
      check("t1_pop_AA", 32'(b), 32'hAA);
      pop_check("t1_pop_hi", b);
      check("t1_pop_BB", 32'(b), 32'hBB);
      wait_reqs("t1_req2_timeout", 2, 20);
      check("t1_req1", 32'(req_at(1)), 32'h08081);

      // Test 2: odd restart address pushes only the high byte.
      do_flush(16'h0003, 16'h0000, 1'b0);
      wait_reqs("t2_req_timeout", 1, 20);
      check("t2_req0", 32'(req_at(0)), 32'h00001);
      pop_check("t2_pop0", b);
      check("t2_pop_11", 32'(b), 32'h11);
      wait_reqs("t2_req2_timeout", 2, 20);
      check("t2_req1", 32'(req_at(1)), 32'h00002);
      pop_check("t2_pop1", b);

      // Test 3: no pops -> exactly three requests fill six bytes.
      do_flush(16'h0400, 16'h2000, 1'b0);
      repeat (40) tick();
      check("t3_req_count", 32'(req_q.size()), 32'd3);
      check("t3_idle", 32'(bus.mem_access), 32'd0);
      check("t3_not_empty", 32'(bus.fifo_empty), 32'd0);
      pop_check("t3_pop0", b);
      repeat (10) tick();
      check("t3_one_free_no_req", 32'(req_q.size()), 32'd3);
      pop_check("t3_pop1", b);
      wait_reqs("t3_req4_timeout", 4, 10);
      check("t3_req3", 32'(req_at(3)), 32'(tb_phys(16'h2000, 16'h0406) >> 1));
      for (int i = 0; i < 6; i++) pop_check("t3_drain", b);

      // Test 4: flush while a delayed request is outstanding.
      mem_lat = 3;
      do_flush(16'h1000, 16'h2000, 1'b0);
      n = 0;
      while (!bus.mem_access && n < 20) begin
         tick();
         n++;
      end
      check("t4_req_started", 32'(bus.mem_access), 32'd1);
      do_flush(16'h0200, 16'h2000, 1'b0);
      check("t4_access_held", 32'(bus.mem_access), 32'd1);
      check("t4_empty_after_flush", 32'(bus.fifo_empty), 32'd1);
      n = 0;
      while (bus.mem_access && n < 20) begin
         tick();
         n++;
      end
      check("t4_access_dropped", 32'(bus.mem_access), 32'd0);
      check("t4_discarded", 32'(bus.fifo_empty), 32'd1);
      wait_reqs("t4_req_timeout", 1, 10);
      check("t4_req0", 32'(req_at(0)), 32'(tb_phys(16'h2000, 16'h0200) >> 1));
      mem_lat = 0;
      pop_check("t4_pop0", b);
      pop_check("t4_pop1", b);

      // Test 5: 16-bit IP wrap inside segment 0xF000.
      do_flush(16'hFFFE, 16'hF000, 1'b0);
      wait_reqs("t5_req_timeout", 2, 30);
      check("t5_req0", 32'(req_at(0)), 32'h7FFFF);
      check("t5_req1", 32'(req_at(1)), 32'h78000);
      for (int i = 0; i < 4; i++) pop_check("t5_pop", b);

      // Test 6: pop while empty, and pop coincident with a flush.
      mem_lat = 20;
      do_flush(16'h0050, 16'h0000, 1'b0);
      prev = bus.fifo_rd_data;
      bus.fifo_rd_en = 1'b1;
      tick();
      bus.fifo_rd_en = 1'b0;
      check("t6_empty_pop_empty", 32'(bus.fifo_empty), 32'd1);
      check("t6_empty_pop_data", 32'(bus.fifo_rd_data), 32'(prev));
      tick();
      check("t6_empty_pop_hold", 32'(bus.fifo_rd_data), 32'(prev));
      mem_lat = 0;
      pop_check("t6_pop0", b);
      wait_nonempty("t6_fill", 100);
      prev = bus.fifo_rd_data;
      do_flush(16'h0777, 16'h0300, 1'b1);
      check("t6_flush_pop_empty", 32'(bus.fifo_empty), 32'd1);
      check("t6_flush_pop_data", 32'(bus.fifo_rd_data), 32'(prev));
      pop_check("t6_pop_after_flush", b);

      // Randomized pops, flushes and memory latency against the stream model.
      for (int i = 0; i < 3000; i++) begin
         n = int'($urandom_range(0, 99));
         if (n < 2) begin
            prev = bus.fifo_rd_data;
            mem_lat = int'($urandom_range(0, 3));
            do_flush(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            check("rnd_flush_data_hold", 32'(bus.fifo_rd_data), 32'(prev));
            check("rnd_flush_empty", 32'(bus.fifo_empty), 32'd1);
         end else if (n < 50) begin
            was_empty = bus.fifo_empty;
            prev = bus.fifo_rd_data;
            bus.fifo_rd_en = 1'b1;
            tick();
            bus.fifo_rd_en = 1'b0;
            if (was_empty) begin
               check("rnd_empty_pop_hold", 32'(bus.fifo_rd_data), 32'(prev));
            end else begin
               check("rnd_pop", 32'(bus.fifo_rd_data), 32'(mem_byte(tb_phys(exp_cs, exp_ip))));
               exp_ip = exp_ip + 16'd1;
            end
         end else begin
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Instruction prefetch stage directly upstream of the ModR/M decoder and immediate reader.
- Fetches 16-bit words from memory at CS:IP and pushes them byte-by-byte into an internal byte queue.
- Consumers drain the queue through the standard fifo_rd_en / fifo_rd_data / fifo_empty read port.
- load_new_ip (jump/call/interrupt) flushes the queue and restarts fetching at new_ip.

Parameters:
- FIFO_DEPTH, 6, queue capacity in bytes (8086-style queue); must be >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- cs  input  16  code segment, sampled whenever a request address is formed.
- new_ip  input  16  restart IP, taken when load_new_ip = 1.
- load_new_ip  input  1  single-cycle flush-and-restart strobe.
- mem_access  output  1  memory read request.
- mem_ack  input  1  one-cycle completion strobe; mem_data valid that cycle.
- mem_address  output  19  physical word address [19:1].
- mem_data  input  16  read data.
- fifo_rd_en  input  1  pop one byte.
- fifo_rd_data  output  8  popped byte, registered.
- fifo_empty  output  1  queue holds no bytes.

Behaviour:
- Reset (reset low, asynchronous):
  - fetch_ip = 0; queue count = 0; mem_access = 0; mem_address = 0; fifo_rd_data = 0; fifo_empty = 1; discard flag = 0; state IDLE.
- Address formation:
  - phys = ({cs,4'b0} + fetch_ip) mod 2^20; mem_address = phys[19:1].
  - fetch_ip is 16-bit and wraps 0xFFFF -> 0x0000 with no carry into cs.
- State machine:
  - IDLE -> FETCH when free slots >= 2, or free slots >= 1 and fetch_ip[0] = 1. mem_access rises on entry.
  - FETCH: mem_access stays high and mem_address stays stable until mem_ack.
    - On ack with fetch_ip odd: push mem_data[15:8]; fetch_ip += 1; go to IDLE.
    - On ack with fetch_ip even: push mem_data[7:0]; latch mem_data[15:8]; fetch_ip += 1; go to WRITE_HI.
  - WRITE_HI: push the latched high byte; fetch_ip += 1; go to IDLE.
  - mem_access deasserts in the cycle after ack. Minimum gap between requests is 1 cycle.
- Queue:
  - fifo_rd_en pops the head; fifo_rd_data updates in the following cycle and holds otherwise.
  - fifo_rd_en while empty is ignored: no underflow, count unchanged.
  - Simultaneous push and pop are both honoured; count is unchanged.
  - The FSM never pushes into a full queue.
- Flush (load_new_ip = 1):
  - Next cycle: count = 0, fifo_empty = 1, fetch_ip = new_ip; any WRITE_HI byte is dropped.
  - A pop in the same cycle is ignored.
  - If a request is outstanding (FETCH without ack), mem_access stays high until ack, that ack's data is discarded, and IDLE is entered. A new request, using the new fetch_ip, is issued the cycle after.
  - load_new_ip coincident with mem_ack: data discarded, fetch_ip = new_ip.
  - Back-to-back flushes: the last one wins.
- load_new_ip during reset is ignored.

Decomposition:
- Shared package holds:
  - PREFETCH_DEPTH default (6).
  - Prefetch state typedef (IDLE, FETCH, WRITE_HI).
  - Physical-address helper function (segment*16 + offset, 20-bit).
- One sub-module, prefetch_fifo: parameterised byte FIFO with write/read/flush ports, count output, registered read data, same clock and reset.

Test Plan:
- Reset with new_ip flush to 0x0100, cs = 0x1000 -> first request mem_address = 0x10100 >> 1 = 0x08080; ack data 0xBBAA gives pops AA then BB; fetch_ip = 0x0102.
- Flush to odd new_ip 0x0003, cs = 0 -> request word address 0x00001; ack 0x1122 pushes only 0x11; next request word address 0x00002.
- No pops, memory always acks after 1 cycle -> exactly 3 requests, count reaches 6, mem_access stays 0 after. One pop frees 1 slot with even fetch_ip -> still no request; a second pop -> request issued.
- Request outstanding (ack delayed 3 cycles), load_new_ip with new_ip 0x0200 -> mem_access held until ack, acked data never appears, fifo_empty = 1. Next request targets 0x0200 + cs*16.
- cs = 0xF000, fetch_ip = 0xFFFE -> fetch covers 0xFFFFE. Next request uses fetch_ip 0x0000, i.e. word address 0xF0000 >> 1 = 0x78000.
- fifo_rd_en while empty, and pop coincident with load_new_ip -> count stays 0 and no spurious fifo_rd_data change.
